period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures an external square wave: period and high time, in i_clk cycles.
- Receive-side counterpart to the team's divided-clock/toggle generators. Used to check generator outputs on-chip and to measure slow external signals.
- Reports one measurement per input period with a single-cycle valid strobe. Flags a missing or stopped input with a timeout.

Parameters:
CNT_WIDTH, 26, width of the period/high-time counters and outputs
TIMEOUT, 26'd60000000, cycles after the last detected rising edge with no new rising edge before o_timeout asserts; legal range 4..2^CNT_WIDTH-1
SYNC_STAGES, 2, number of synchroniser flops on i_sig; minimum 2

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_sig  input  1  asynchronous square wave to measure
i_enable  input  1  1 = measure; 0 = idle, internal counters cleared
o_period  output  CNT_WIDTH  cycles between the last two detected rising edges
o_high_time  output  CNT_WIDTH  cycles from a detected rising edge to the next detected falling edge, within the same period as o_period
o_valid  output  1  one-cycle strobe; o_period and o_high_time updated this cycle
o_timeout  output  1  level; no rising edge for TIMEOUT cycles

Behaviour:
- Clock and reset: reset i_reset, asynchronous, active-high; clock i_clk.
- Reset values: all outputs 0; state IDLE; all counters 0; sync chain 0.
- Input conditioning:
  - i_sig passes through SYNC_STAGES flops, then one history flop.
  - rise = sync_out & ~hist; fall = ~sync_out & hist.
  - Detection latency is fixed, so measured values are unaffected by it.
- Counter cnt: cleared to 0 in the cycle rise is seen; otherwise increments by 1 each cycle in ARM-complete/MEAS. TIMEOUT bound guarantees it never wraps.
- States: IDLE, ARM, MEAS.
  - IDLE: entered when i_enable=0. cnt cleared. o_period, o_high_time and o_timeout hold. Next state is ARM when i_enable=1.
  - ARM: waits for first rise. Falls are ignored. On rise: cnt<=0, go to MEAS, o_timeout<=0, no o_valid.
  - MEAS, on fall: hi_tmp<=cnt+1.
  - MEAS, on rise:
    - o_period<=cnt+1; o_high_time<=hi_tmp; cnt<=0.
    - o_valid=1 in the cycle after rise (registered; outputs change on the same edge as o_valid asserts).
    - o_timeout<=0.
  - MEAS, when cnt+1==TIMEOUT with no rise that cycle: o_timeout<=1; go to ARM. o_period and o_high_time hold.
- o_valid: high exactly one cycle per measured period; never high in IDLE/ARM or on the arming edge.
- Example: an input high 5 cycles, low 5 cycles gives o_period=10, o_high_time=5.
- Simultaneous events:
  - i_enable=0 and rise in the same cycle: i_enable wins; go to IDLE, no o_valid.
  - Rise and timeout condition in the same cycle: rise wins, no timeout.
- Reset mid-measurement: immediate return to reset values; the first rise after release only arms.
- Input with no full period before TIMEOUT (stuck high or low): o_timeout=1; o_valid stays low.

Test Plan:
- Reset: assert i_reset mid-stream with o_period=10 held -> o_period=0, o_high_time=0, o_valid=0, o_timeout=0 immediately, without waiting for a clock edge.
- 50% duty: i_enable=1, i_sig toggles every 5 cycles -> first o_valid one cycle after the second detected rise, o_period=10, o_high_time=5; o_valid repeats every 10 cycles.
- Asymmetric duty: high 3 / low 7 for 4 periods -> four o_valid strobes, each o_period=10, o_high_time=3.
- Timeout: TIMEOUT=100, i_sig stops low after a valid measurement -> o_timeout=1 exactly 100 cycles after the last rise detection, o_period held. Restart at period 20 -> o_timeout=0 at the first rise, next o_valid reports o_period=20.
- Enable drop: deassert i_enable mid-period for 7 cycles, then re-enable -> no o_valid while disabled, outputs held, first rise after re-enable only arms, o_valid at the second rise.
- Simultaneous: drop i_enable in the same cycle rise is detected -> no o_valid, state IDLE.

Source files
------------

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the period and high time of an asynchronous square wave, in i_clk
// cycles. Each rising edge closes one period and reports it with a one-cycle
// o_valid strobe. If no new rising edge arrives within TIMEOUT cycles of the
// last one, o_timeout is raised and the meter re-arms on the next rising edge.
//
// Parameters
//   CNT_WIDTH   : width of the internal counter and of o_period/o_high_time
//   TIMEOUT     : cycles after a rising edge without a new one before timeout
//                 (4 .. 2^CNT_WIDTH-1, so the counter can never wrap)
//   SYNC_STAGES : synchroniser depth on i_sig (>= 2)
//
// Ports
//   i_clk       : system clock
//   i_reset     : asynchronous, active-high reset
//   i_sig       : asynchronous square wave to measure
//   i_enable    : 1 = measure, 0 = idle with counter cleared, outputs held
//   o_period    : cycles between the last two detected rising edges
//   o_high_time : cycles from that period's rising edge to its falling edge
//   o_valid     : one-cycle strobe, o_period/o_high_time updated this cycle
//   o_timeout   : level, no rising edge seen for TIMEOUT cycles
// -----------------------------------------------------------------------------
module period_meter #(
  parameter int unsigned          CNT_WIDTH   = 26,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT     = 26'd60000000,
  parameter int unsigned          SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_sig,
  input  logic                 i_enable,
  output logic [CNT_WIDTH-1:0] o_period,
  output logic [CNT_WIDTH-1:0] o_high_time,
  output logic                 o_valid,
  output logic                 o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_MEAS = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_sync_out;
  logic                   w_rise;
  logic                   w_fall;

  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_hi_tmp;
  logic [CNT_WIDTH-1:0]   w_cnt_inc;

  logic                   w_arm_rise;
  logic                   w_meas_rise;
  logic                   w_meas_fall;
  logic                   w_timeout_hit;
  logic                   w_cnt_run;

  // Input conditioning: synchroniser chain followed by one history flop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_sync_out & ~r_hist;
  assign w_fall     = ~w_sync_out & r_hist;

  // cnt holds (cycles since rise - 1), so cnt+1 is the elapsed cycle count.
  assign w_cnt_inc  = r_cnt + CNT_WIDTH'(1);

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and event decode. Disable overrides everything; in MEAS a
  // rise takes precedence over the timeout condition in the same cycle.
  always_comb begin
    w_next_state  = r_state;
    w_arm_rise    = 1'b0;
    w_meas_rise   = 1'b0;
    w_meas_fall   = 1'b0;
    w_timeout_hit = 1'b0;
    w_cnt_run     = 1'b0;
    if (!i_enable) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next_state = S_ARM;
        end
        S_ARM: begin
          if (w_rise) begin
            w_arm_rise   = 1'b1;
            w_next_state = S_MEAS;
          end
        end
        S_MEAS: begin
          w_meas_fall = w_fall;
          if (w_rise) begin
            w_meas_rise = 1'b1;
          end else if (w_cnt_inc == TIMEOUT) begin
            w_timeout_hit = 1'b1;
            w_next_state  = S_ARM;
          end else begin
            w_cnt_run = 1'b1;
          end
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  // Counter, high-time capture and registered outputs. The counter only runs
  // inside a measured period; everywhere else it sits at zero, which also
  // covers the clear on every detected rise.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_hi_tmp    <= '0;
      o_period    <= '0;
      o_high_time <= '0;
      o_valid     <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_valid <= w_meas_rise;

      if (w_cnt_run) begin
        r_cnt <= w_cnt_inc;
      end else begin
        r_cnt <= '0;
      end

      if (w_meas_fall) begin
        r_hi_tmp <= w_cnt_inc;
      end

      if (w_meas_rise) begin
        o_period    <= w_cnt_inc;
        o_high_time <= r_hi_tmp;
      end

      if (w_timeout_hit) begin
        o_timeout <= 1'b1;
      end else if (w_arm_rise || w_meas_rise) begin
        o_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
//
// Scoreboard bench for period_meter. A reference model works on timestamps of
// detected edges (period = rise-to-rise distance, high = rise-to-fall distance,
// timeout = TIMEOUT cycles since the last rise) and pushes each expected
// measurement into a queue; a monitor pops and compares on every o_valid and
// checks the held output levels every cycle.
// -----------------------------------------------------------------------------
module tb_period_meter;

  localparam int CW = 26;
  localparam int SS = 2;
  localparam int TO = 100;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_sig;
  logic          i_enable;
  logic [CW-1:0] o_period;
  logic [CW-1:0] o_high_time;
  logic          o_valid;
  logic          o_timeout;

  period_meter #(
    .CNT_WIDTH  (CW),
    .TIMEOUT    (CW'(TO)),
    .SYNC_STAGES(SS)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_sig      (i_sig),
    .i_enable   (i_enable),
    .o_period   (o_period),
    .o_high_time(o_high_time),
    .o_valid    (o_valid),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int unsigned period;
    int unsigned high;
    int unsigned due;
  } meas_t;

  meas_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_line[0] is the most recent i_sig sample; detected level and its
  // previous value are the samples SS and SS+1 cycles old.
  logic [SS:0]  m_line;
  logic         m_en_prev;
  logic         m_have_ref;
  logic         m_timeout;
  logic         m_rise;
  logic         m_fall;
  int unsigned  m_t_rise;
  int unsigned  m_t_fall;
  int unsigned  m_period;
  int unsigned  m_high;
  int unsigned  cyc = 0;

  initial begin
    m_line = '0; m_en_prev = 1'b0; m_have_ref = 1'b0; m_timeout = 1'b0;
    m_t_rise = 0; m_t_fall = 0; m_period = 0; m_high = 0;
    forever begin
      @(posedge i_clk or posedge i_reset);
      if (i_reset) begin
        m_line = '0; m_en_prev = 1'b0; m_have_ref = 1'b0; m_timeout = 1'b0;
        m_period = 0; m_high = 0;
        sb.delete();
        if (i_clk) cyc++;
      end else begin
        m_rise = m_line[SS-1] & ~m_line[SS];
        m_fall = ~m_line[SS-1] & m_line[SS];
        if (!i_enable) begin
          m_have_ref = 1'b0;
        end else if (m_en_prev) begin
          if (m_rise) begin
            if (m_have_ref) begin
              m_period = cyc - m_t_rise;
              m_high   = m_t_fall - m_t_rise;
              sb.push_back('{m_period, m_high, cyc + 1});
            end
            m_t_rise   = cyc;
            m_have_ref = 1'b1;
            m_timeout  = 1'b0;
          end else if (m_have_ref && (cyc - m_t_rise == TO)) begin
            m_timeout  = 1'b1;
            m_have_ref = 1'b0;
          end
          if (m_fall && m_have_ref) m_t_fall = cyc;
        end
        m_en_prev = i_enable;
        m_line    = {m_line[SS-1:0], i_sig};
        cyc++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    meas_t m;
    forever begin
      @(negedge i_clk);
      if (i_reset === 1'b0) begin
        chk("timeout_level", o_timeout, m_timeout);
        chk("period_level", o_period, m_period);
        chk("high_level", o_high_time, m_high);
        if (o_valid) begin
          if (sb.size() == 0) begin
            chk("spurious_valid", o_valid, 0);
          end else begin
            m = sb.pop_front();
            chk("valid_cycle", cyc, m.due);
            chk("valid_period", o_period, m.period);
            chk("valid_high", o_high_time, m.high);
          end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
          chk("missing_valid", o_valid, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    repeat (n) begin
      i_sig = 1'b1; step(hi);
      i_sig = 1'b0; step(lo);
    end
  endtask

  initial begin
    int hi, lo, dis;
    i_reset = 1'b1; i_enable = 1'b0; i_sig = 1'b0;
    #1;
    chk("rst_period", o_period, 0);
    chk("rst_high", o_high_time, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_timeout", o_timeout, 0);
    step(3);
    i_reset = 1'b0; i_enable = 1'b1;

    // 50% duty, then asymmetric duty.
    wave(5, 5, 6);
    wave(3, 7, 4);
    i_sig = 1'b1; step(3); i_sig = 1'b0; step(12);
    chk("pre_reset_period", o_period, 10);
    chk("pre_reset_high", o_high_time, 3);

    // Asynchronous reset mid-stream: outputs clear before any clock edge.
    i_reset = 1'b1;
    #1;
    chk("async_rst_period", o_period, 0);
    chk("async_rst_high", o_high_time, 0);
    chk("async_rst_valid", o_valid, 0);
    chk("async_rst_timeout", o_timeout, 0);
    step(2);
    i_reset = 1'b0;

    // Measure, then stop low long enough to time out, then restart at 20.
    wave(5, 5, 3);
    i_sig = 1'b1; step(5); i_sig = 1'b0; step(150);
    chk("timeout_set", o_timeout, 1);
    chk("timeout_hold_period", o_period, 10);
    wave(10, 10, 4);

    // Enable drop mid-period for 7 cycles.
    i_sig = 1'b1; step(3);
    i_enable = 1'b0; step(2);
    i_sig = 1'b0; step(5);
    i_enable = 1'b1; step(3);
    wave(5, 5, 4);

    // Disable in the very cycle a rise is detected.
    i_sig = 1'b1; step(SS);
    i_enable = 1'b0; step(1);
    i_enable = 1'b1; step(4);
    i_sig = 1'b0; step(5);
    wave(5, 5, 3);

    // Randomised periods, some longer than TIMEOUT, occasional enable drops.
    for (int k = 0; k < 60; k++) begin
      hi = int'($urandom_range(1, 40));
      lo = int'($urandom_range(1, 70));
      i_sig = 1'b1; step(hi);
      i_sig = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        dis = int'($urandom_range(1, 10));
        i_enable = 1'b0; step(dis);
        i_enable = 1'b1;
      end
      step(lo);
    end
    step(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
